bpm2per: RTL

//  Converts a tempo in BPM into a beat period counted in pulse ticks: per = DIVIDEND / bpm.

---
 rtl/bpm2per.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bpm2per.sv
// bpm2per: converts a BPM value into a beat period in pulse ticks and regenerates the beat strobe.
// Optional feature macro BPM2PER_SAT_EN clamps the period to BPMPER_MAX.
module bpm2per #(
   parameter int BPM_MAX    = 250,
   parameter int BPM_W      = 8,
   parameter int DIVIDEND   = 11_718_750,
   parameter int PER_W      = 24,
   parameter int BPMPER_MAX = 62_600
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [BPM_W-1:0] bpm_i,
   input  logic             bpm_valid_i,
   input  logic             pulse_i,
   output logic [PER_W-1:0] per_o,
   output logic             per_valid_o,
   output logic             busy_o,
   output logic             beat_o
);
   localparam int               CNT_W = $clog2(PER_W + 1);
   localparam logic [BPM_W-1:0] BMAX  = BPM_W'(BPM_MAX);
   localparam logic [PER_W-1:0] DIV_V = PER_W'(DIVIDEND);
   localparam logic [PER_W-1:0] SAT_V = PER_W'(BPMPER_MAX);
`ifdef BPM2PER_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
   state_t state, state_nxt;

   logic [BPM_W-1:0] b;
   logic [BPM_W:0]   rem;
   logic [PER_W-1:0] quo;
   logic [CNT_W-1:0] cnt;
   logic [BPM_W+1:0] trial;
   logic             take;
   logic [BPM_W:0]   rem_nxt;
   logic [PER_W-1:0] result;
   logic [PER_W-1:0] per_active;
   logic [PER_W-1:0] pcnt;

   function automatic logic [PER_W-1:0] saturate(input logic [PER_W-1:0] q);
      if (SAT_EN && (q > SAT_V)) return SAT_V;
      return q;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bpm_valid_i) state_nxt = LOAD;
         LOAD:    state_nxt = (b == '0) ? DONE : COMPUTE;
         COMPUTE: if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_o = (state != IDLE);

   // Restoring division step; the remainder stays below b, so the trial never overflows.
   always_comb begin
      trial   = {rem, quo[PER_W-1]};
      take    = (trial >= {2'b00, b});
      rem_nxt = take ? (trial[BPM_W:0] - {1'b0, b}) : trial[BPM_W:0];
      result  = saturate((b == '0) ? '1 : quo);
   end

   // bpm_i is captured with the request so it may change while the divider runs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         b   <= '0;
         rem <= '0;
         quo <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (bpm_valid_i) b <= (bpm_i > BMAX) ? BMAX : bpm_i;
            LOAD: begin
               rem <= '0;
               quo <= DIV_V;
               cnt <= CNT_W'(PER_W);
            end
            COMPUTE: begin
               rem <= rem_nxt;
               quo <= {quo[PER_W-2:0], take};
               cnt <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // A reload restarts the beat phase and swallows any pulse arriving on the same edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         per_o       <= '0;
         per_valid_o <= 1'b0;
         per_active  <= '0;
         pcnt        <= '0;
         beat_o      <= 1'b0;
      end else begin
         per_valid_o <= 1'b0;
         beat_o      <= 1'b0;
         if (state == DONE) begin
            per_o       <= result;
            per_valid_o <= 1'b1;
            per_active  <= result;
            pcnt        <= '0;
         end else if (pulse_i && (per_active != '0)) begin
            if (pcnt == per_active - PER_W'(1)) begin
               beat_o <= 1'b1;
               pcnt   <= '0;
            end else begin
               pcnt <= pcnt + PER_W'(1);
            end
         end
      end
   end
endmodule
